// File: rtl/addr_map_pkg.sv
// addr_map_pkg
//    Shared definitions for the bus address decoder:
//    - decoder FSM state encoding
//    - default memory map: program, data, peripheral and boot windows
//    - default wait-state counts per window
package addr_map_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   // Default memory map (inclusive bounds), region index 0..3
   localparam logic [31:0] PROG_BASE = 32'h0000_0240;
   localparam logic [31:0] PROG_LIM  = 32'h0000_123F;
   localparam logic [31:0] DATA_BASE = 32'h0000_1240;
   localparam logic [31:0] DATA_LIM  = 32'h0000_1FFF;
   localparam logic [31:0] PERI_BASE = 32'h0000_2000;
   localparam logic [31:0] PERI_LIM  = 32'h0000_2FFF;
   localparam logic [31:0] BOOT_BASE = 32'h0000_3000;
   localparam logic [31:0] BOOT_LIM  = 32'h0000_3FFF;

   localparam logic [7:0] PROG_WAIT = 8'd0;
   localparam logic [7:0] DATA_WAIT = 8'd0;
   localparam logic [7:0] PERI_WAIT = 8'd2;
   localparam logic [7:0] BOOT_WAIT = 8'd1;

   // Packed so that region k sits at bits [k*W +: W]
   localparam logic [4*32-1:0] DEF_BASES  = {BOOT_BASE, PERI_BASE, DATA_BASE, PROG_BASE};
   localparam logic [4*32-1:0] DEF_LIMITS = {BOOT_LIM,  PERI_LIM,  DATA_LIM,  PROG_LIM};
   localparam logic [4*8-1:0]  DEF_WAITS  = {BOOT_WAIT, PERI_WAIT, DATA_WAIT, PROG_WAIT};

endpackage

// File: rtl/addr_range_match.sv
// addr_range_match
//    Combinational single-window comparator.
//    Ports:
//       addr_i  : address under test
//       base_i  : inclusive lower bound of the window
//       limit_i : inclusive upper bound of the window
//       hit_o   : 1 when base_i <= addr_i <= limit_i (unsigned)
module addr_range_match #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] limit_i,
   output logic              hit_o
);

   assign hit_o = (addr_i >= base_i) && (addr_i <= limit_i);

endmodule

// File: rtl/addr_decode_ws.sv
// addr_decode_ws
//    Registered address decoder with per-region wait states. Maps a request
//    address onto one of N_REG inclusive windows, produces a one-hot chip
//    select and region-relative offset, stalls WAITS[k] cycles, then pulses
//    ready for one cycle. Unmapped addresses complete with fault.
//    Ports:
//       clk    : system clock, rising edge
//       rst    : synchronous active-high reset
//       req    : access request, only looked at in IDLE
//       addr   : request address, sampled with req
//       cs     : one-hot chip select (registered)
//       offset : addr - BASE[k] of the hit region (registered)
//       ready  : single-cycle completion strobe
//       fault  : high with ready when the access hit no region
//       busy   : high whenever the FSM is not IDLE
module addr_decode_ws
   import addr_map_pkg::*;
#(
   parameter int                      ADDR_W = 32,
   parameter int                      N_REG  = 4,
   parameter logic [N_REG*ADDR_W-1:0] BASES  = DEF_BASES,
   parameter logic [N_REG*ADDR_W-1:0] LIMITS = DEF_LIMITS,
   parameter logic [N_REG*8-1:0]      WAITS  = DEF_WAITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic [N_REG-1:0]  cs,
   output logic [ADDR_W-1:0] offset,
   output logic              ready,
   output logic              fault,
   output logic              busy
);

   logic [N_REG-1:0] hit;

   for (genvar k = 0; k < N_REG; k++) begin : g_match
      addr_range_match #(.ADDR_W(ADDR_W)) u_match (
         .addr_i  (addr),
         .base_i  (BASES[k*ADDR_W +: ADDR_W]),
         .limit_i (LIMITS[k*ADDR_W +: ADDR_W]),
         .hit_o   (hit[k])
      );
   end

   // Priority encode: scan from the top index down so the lowest
   // matching index is the last one written and therefore wins.
   logic              dec_hit;
   logic [N_REG-1:0]  dec_cs;
   logic [ADDR_W-1:0] dec_off;
   logic [7:0]        dec_wait;

   always_comb begin
      dec_hit  = 1'b0;
      dec_cs   = '0;
      dec_off  = '0;
      dec_wait = '0;
      for (int k = N_REG - 1; k >= 0; k--) begin
         if (hit[k]) begin
            dec_hit   = 1'b1;
            dec_cs    = '0;
            dec_cs[k] = 1'b1;
            // Cannot underflow: a hit implies addr >= base.
            dec_off   = addr - BASES[k*ADDR_W +: ADDR_W];
            dec_wait  = WAITS[k*8 +: 8];
         end
      end
   end

   state_e            state_q;
   logic [7:0]        cnt_q;
   logic [N_REG-1:0]  cs_q;
   logic [ADDR_W-1:0] offset_q;
   logic              ready_q;
   logic              fault_q;
   logic              busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cs_q     <= '0;
         offset_q <= '0;
         ready_q  <= 1'b0;
         fault_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               fault_q <= 1'b0;
               if (req) begin
                  busy_q <= 1'b1;
                  if (dec_hit) begin
                     cs_q     <= dec_cs;
                     offset_q <= dec_off;
                     if (dec_wait != 8'd0) begin
                        cnt_q   <= dec_wait;
                        state_q <= WAIT;
                     end else begin
                        // ready is registered so it lands in the DONE cycle
                        ready_q <= 1'b1;
                        state_q <= DONE;
                     end
                  end else begin
                     cs_q     <= '0;
                     offset_q <= '0;
                     fault_q  <= 1'b1;
                     ready_q  <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  ready_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               ready_q  <= 1'b0;
               fault_q  <= 1'b0;
               cs_q     <= '0;
               offset_q <= '0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cs     = cs_q;
   assign offset = offset_q;
   assign ready  = ready_q;
   assign fault  = fault_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_addr_decode_ws.sv
module tb_addr_decode_ws;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, req_ov = 1'b0;
   logic [31:0] addr = '0, addr_ov = '0;
   logic [3:0]  cs, cs_ov;
   logic [31:0] offset, offset_ov;
   logic        ready, fault, busy, ready_ov, fault_ov, busy_ov;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   addr_decode_ws dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr),
      .cs(cs), .offset(offset), .ready(ready), .fault(fault), .busy(busy)
   );

   // Regions 0 and 1 overlap on 0x500..0x5FF
   addr_decode_ws #(
      .ADDR_W(32), .N_REG(4),
      .BASES ({32'h3000, 32'h2000, 32'h0500, 32'h0400}),
      .LIMITS({32'h3FFF, 32'h2FFF, 32'h06FF, 32'h05FF}),
      .WAITS ({8'd0, 8'd0, 8'd0, 8'd0})
   ) dut_ov (
      .clk(clk), .rst(rst), .req(req_ov), .addr(addr_ov),
      .cs(cs_ov), .offset(offset_ov), .ready(ready_ov), .fault(fault_ov), .busy(busy_ov)
   );

   // Reference memory map, written out independently of the DUT parameters
   logic [31:0] base_m [4] = '{32'h0240, 32'h1240, 32'h2000, 32'h3000};
   logic [31:0] lim_m  [4] = '{32'h123F, 32'h1FFF, 32'h2FFF, 32'h3FFF};
   int          wait_m [4] = '{0, 0, 2, 1};

   function automatic void ref_decode(input logic [31:0] a, output logic [3:0] ecs,
                                      output logic [31:0] eoff, output bit eflt, output int w);
      ecs = '0; eoff = '0; eflt = 1'b1; w = 0;
      for (int k = 0; k < 4; k++)
         if (eflt && a >= base_m[k] && a <= lim_m[k]) begin
            ecs  = 4'(1 << k);
            eoff = a - base_m[k];
            eflt = 1'b0;
            w    = wait_m[k];
         end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit ov, input logic r, input logic [31:0] a);
      if (ov) begin req_ov = r; addr_ov = a; end
      else    begin req    = r; addr    = a; end
   endtask

   task automatic get(input bit ov, output logic [3:0] c, output logic [31:0] o,
                      output logic rd, output logic f, output logic b);
      if (ov) begin c = cs_ov; o = offset_ov; rd = ready_ov; f = fault_ov; b = busy_ov; end
      else    begin c = cs;    o = offset;    rd = ready;    f = fault;    b = busy;    end
   endtask

   // One full transaction: accept, W wait cycles, DONE, back to IDLE
   task automatic run_txn(input bit ov, input logic [31:0] a, input logic [3:0] ecs,
                          input logic [31:0] eoff, input bit eflt, input int w, input string nm);
      logic [3:0] c; logic [31:0] o; logic rd, f, b;
      @(negedge clk); drive(ov, 1'b1, a);
      @(posedge clk); #1; drive(ov, 1'b0, a);
      for (int cyc = 1; cyc <= w + 1; cyc++) begin
         get(ov, c, o, rd, f, b);
         chk({nm, ".cs"},    32'(c),  32'(ecs));
         chk({nm, ".off"},   o,       eoff);
         chk({nm, ".busy"},  32'(b),  32'd1);
         chk({nm, ".ready"}, 32'(rd), 32'(cyc == w + 1));
         chk({nm, ".fault"}, 32'(f),  32'(eflt && cyc == w + 1));
         if (cyc < w + 1) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      get(ov, c, o, rd, f, b);
      chk({nm, ".idle_busy"},  32'(b),  32'd0);
      chk({nm, ".idle_ready"}, 32'(rd), 32'd0);
      chk({nm, ".idle_fault"}, 32'(f),  32'd0);
      chk({nm, ".idle_cs"},    32'(c),  32'd0);
      chk({nm, ".idle_off"},   o,       32'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [3:0]  ecs;
      logic [31:0] eoff;
      bit          eflt;
      int          w;
   } vec_t;

   vec_t tbl [10];

   logic [31:0] edges [12] = '{32'h0240, 32'h123F, 32'h1240, 32'h1FFF, 32'h2000, 32'h2FFF,
                               32'h3000, 32'h3FFF, 32'h023F, 32'h4000, 32'h0000, 32'hFFFF_FFFF};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ecs; logic [31:0] eoff; bit eflt; int w, seen;
      logic [31:0] a;

      tbl[0] = '{32'h0230, 4'b0000, 32'h000, 1'b1, 0};
      tbl[1] = '{32'h0240, 4'b0001, 32'h000, 1'b0, 0};
      tbl[2] = '{32'h123F, 4'b0001, 32'hFFF, 1'b0, 0};
      tbl[3] = '{32'h1240, 4'b0010, 32'h000, 1'b0, 0};
      tbl[4] = '{32'h1FFF, 4'b0010, 32'hDBF, 1'b0, 0};
      tbl[5] = '{32'h2000, 4'b0100, 32'h000, 1'b0, 2};
      tbl[6] = '{32'h2F0F, 4'b0100, 32'hF0F, 1'b0, 2};
      tbl[7] = '{32'h3000, 4'b1000, 32'h000, 1'b0, 1};
      tbl[8] = '{32'h3FFF, 4'b1000, 32'hFFF, 1'b0, 1};
      tbl[9] = '{32'h4000, 4'b0000, 32'h000, 1'b1, 0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.cs", 32'(cs), 0);     chk("rst.off", offset, 0);
      chk("rst.ready", 32'(ready), 0); chk("rst.fault", 32'(fault), 0);
      chk("rst.busy", 32'(busy), 0);
      @(negedge clk); rst = 1'b0;

      foreach (tbl[i])
         run_txn(1'b0, tbl[i].a, tbl[i].ecs, tbl[i].eoff, tbl[i].eflt, tbl[i].w, $sformatf("tbl%0d", i));

      // req during WAIT and DONE must be ignored
      @(negedge clk); drive(1'b0, 1'b1, 32'h2F0F);
      @(posedge clk); #1; drive(1'b0, 1'b1, 32'h0240);
      chk("ign.c1_cs", 32'(cs), 32'h4); chk("ign.c1_off", offset, 32'hF0F);
      chk("ign.c1_ready", 32'(ready), 0);
      @(posedge clk); #1;
      chk("ign.c2_ready", 32'(ready), 0); chk("ign.c2_cs", 32'(cs), 32'h4);
      @(posedge clk); #1;
      chk("ign.c3_ready", 32'(ready), 1); chk("ign.c3_off", offset, 32'hF0F);
      drive(1'b0, 1'b0, 32'h0);
      seen = 0;
      repeat (4) begin @(posedge clk); #1; if (ready) seen++; end
      chk("ign.no_second_ready", seen, 0);
      chk("ign.busy", 32'(busy), 0);

      // Reset during the first WAIT cycle aborts the access
      @(negedge clk); drive(1'b0, 1'b1, 32'h2F0F);
      @(posedge clk); #1; drive(1'b0, 1'b0, 32'h0);
      chk("rstw.busy_pre", 32'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("rstw.cs", 32'(cs), 0); chk("rstw.off", offset, 0);
      chk("rstw.ready", 32'(ready), 0); chk("rstw.fault", 32'(fault), 0);
      chk("rstw.busy", 32'(busy), 0);
      seen = 0;
      repeat (10) begin @(posedge clk); #1; if (ready) seen++; end
      chk("rstw.no_ready", seen, 0);

      // Overlapping windows: lowest index wins
      run_txn(1'b1, 32'h0500, 4'b0001, 32'h100, 1'b0, 0, "ov500");
      run_txn(1'b1, 32'h0600, 4'b0010, 32'h100, 1'b0, 0, "ov600");
      run_txn(1'b1, 32'h03FF, 4'b0000, 32'h000, 1'b1, 0, "ov3ff");

      // Randomized addresses against the reference model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) a = edges[$urandom_range(0, 11)];
         else                            a = 32'($urandom_range(0, 32'h4FFF));
         ref_decode(a, ecs, eoff, eflt, w);
         run_txn(1'b0, a, ecs, eoff, eflt, w, $sformatf("rnd%0d_%0h", i, a));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
